// File: rtl/alu_spi_pkg.sv
// Shared definitions for the SPI ALU master.
// Covers opcodes, frame lengths, FSM states and the request frame packer.
package alu_spi_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_XOR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  localparam int TX_BITS = 67;
  localparam int RX_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_GAP  = 3'd2,
    ST_RX   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Request frame goes out opcode first, then opa, then opb, all MSB-first.
  function automatic logic [TX_BITS-1:0] pack_frame(input logic [2:0]  op,
                                                    input logic [31:0] a,
                                                    input logic [31:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator.
// sclk toggles every CLK_DIV enabled cycles; rise/fall strobes mark the cycle before each edge.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick = i_en && (r_div == DIV_LAST);
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  // Dropping the enable parks sclk low and restarts the divider for the next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_sclk <= !r_sclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/spi_alu_master.sv
// SPI master that ships an ALU request (opcode, opa, opb) to a slave,
// waits a fixed gap with nss high, then clocks back a 32-bit result.
module spi_alu_master import alu_spi_pkg::*; #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [31:0] req_opa,
  input  logic [31:0] req_opb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        nss,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        busy,
  output state_e      o_state
);

  // Handshakes: a request transfers on a cycle where req_valid and req_ready
  // are both high; a response transfers where rsp_valid and rsp_ready are both high.

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_e              r_state;
  state_e              w_next;
  logic [TX_BITS-1:0]  r_shift;
  logic [6:0]          r_bit_cnt;
  logic [15:0]         r_gap_cnt;
  logic [RX_BITS-1:0]  r_result;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_valid;
  logic                r_req_ready;
  logic                w_accept;
  logic                w_last_bit;
  logic                w_sclk_en;
  logic                w_rise;
  logic                w_fall;
  logic                w_sclk;

  assign w_accept   = req_valid && r_req_ready;
  assign w_last_bit = (r_bit_cnt == 7'd1);
  assign w_sclk_en  = (r_state == ST_TX) || (r_state == ST_RX);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_sclk_en),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_sclk (w_sclk)
  );

  assign nss       = !w_sclk_en;
  assign sclk      = w_sclk;
  assign mosi      = (r_state == ST_TX) ? r_shift[TX_BITS-1] : 1'b0;
  assign busy      = (r_state != ST_IDLE);
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign o_state   = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_TX;
      ST_TX:   if (w_fall && w_last_bit) w_next = ST_GAP;
      ST_GAP:  if (r_gap_cnt == GAP_LAST) w_next = ST_RX;
      ST_RX:   if (w_fall && w_last_bit) w_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // req_ready is registered so it stays low through reset and rises one edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_result    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift   <= pack_frame(req_opcode, req_opa, req_opb);
            r_bit_cnt <= 7'(TX_BITS);
            r_result  <= '0;
          end
        end
        ST_TX: begin
          if (w_fall) begin
            r_shift   <= {r_shift[TX_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 7'd1;
          end
        end
        ST_GAP: begin
          if (w_next == ST_RX) begin
            r_gap_cnt <= '0;
            r_bit_cnt <= 7'(RX_BITS);
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        ST_RX: begin
          if (w_rise) r_result <= {r_result[RX_BITS-2:0], miso};
          if (w_fall) begin
            r_bit_cnt <= r_bit_cnt - 7'd1;
            if (w_last_bit) begin
              r_rsp_data  <= r_result;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_alu_master.md
SPI_ALU_MASTER -- requirements
Module: spi_alu_master

Interface
REQ-001 Parameter CLK_DIV, default 4, sclk half-period in clock cycles; SHALL be >= 1.
REQ-002 Parameter GAP_CYCLES, default 8, clock cycles nss is held high between request and response frames; SHALL be >= 1.
REQ-003 clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 req_valid  input  1  request present; req_ready  output  1  request accepted when both are high.
REQ-006 req_opcode  input  3  ALU opcode; req_opa  input  32  operand A; req_opb  input  32  operand B.
REQ-007 rsp_valid  output  1  result available; rsp_ready  input  1  result consumed when both are high; rsp_data  output  32  result.
REQ-008 nss  output  1  SPI select, active-low; sclk  output  1  SPI clock; mosi  output  1  serial data out; miso  input  1  serial data in.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, TX, GAP, RX, DONE.
REQ-011 IDLE: req_ready=1; on req_valid&req_ready, latch {opcode,opa,opb} into a 67-bit shift register, load the bit counter with 67, and go to TX next cycle.
REQ-012 TX: nss=0 from the first TX cycle; mosi SHALL present shift-register bit 66 (opcode[2] first, then opa MSB-first, then opb MSB-first).
REQ-013 SPI mode 0: sclk idle low; sclk rises CLK_DIV cycles after each new mosi bit; it falls CLK_DIV cycles later, when the next bit is shifted onto mosi.
REQ-014 Each bit SHALL occupy exactly 2*CLK_DIV cycles; TX SHALL last 67*2*CLK_DIV cycles (536 at default) and produce exactly 67 rising sclk edges.
REQ-015 After the 67th falling edge: nss=1, sclk=0, mosi=0, go to GAP.
REQ-016 GAP: nss held high for exactly GAP_CYCLES cycles, then go to RX.
REQ-017 RX: nss=0, mosi=0; generate 32 sclk pulses with the same timing as TX; on the cycle each rising edge is driven, miso SHALL be shifted into the LSB of a 32-bit result register (MSB received first).
REQ-018 After the 32nd falling edge: nss=1, sclk=0, rsp_data=result register, rsp_valid=1, go to DONE.
REQ-019 DONE: rsp_valid and rsp_data SHALL stay stable until rsp_ready=1; on that cycle rsp_valid clears and FSM returns to IDLE; req_ready rises the following cycle.
REQ-020 req_ready SHALL be 0 in all states except IDLE; inputs changing outside IDLE SHALL have no effect.
REQ-021 The divider counter SHALL wrap from CLK_DIV-1 to 0; the bit counter SHALL never underflow (terminal value 0 triggers state exit).
REQ-022 rsp_ready asserted while rsp_valid=0 SHALL be ignored.
REQ-023 nss SHALL never be low while the FSM is in IDLE, GAP or DONE; no sclk edge SHALL occur while nss=1.
REQ-024 miso SHALL be sampled without a synchronizer (slave shares clock).

Reset
REQ-025 On reset low, asynchronously: state=IDLE, nss=1, sclk=0, mosi=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, all counters and shift registers 0.
REQ-026 req_ready SHALL rise on the first clock edge after reset release.
REQ-027 Reset asserted mid-frame SHALL abort the transfer immediately, with nss high and no partial result presented afterwards.

Structure
REQ-028 A shared package alu_spi_pkg SHALL hold the opcode enum (3 bits; SHL=3'b100, SHR=3'b101), TX_BITS=67, RX_BITS=32 and the FSM state typedef.
REQ-029 sclk and divider generation SHALL be one sub-module, spi_sclk_gen (enable in; rise/fall strobe and sclk out).

Verification
REQ-030 Each scenario SHALL run against an SPI slave model that returns a fixed 32-bit word and checks the 67-bit stream.
- opcode=3'b100, opa=0x00000001, opb=0x00000005, slave returns 0x00000020 -> mosi stream 3'b100,0x00000001,0x00000005; rsp_data=0x00000020; nss-low durations 536 and 256 cycles; GAP=8 cycles.
- Slave returns 0xA5A5_5A5A, rsp_ready held low 20 cycles -> rsp_valid stays 1, rsp_data stable, req_ready=0 throughout, IDLE one cycle after rsp_ready.
- req_valid held high with new values during TX -> the second request is accepted only after DONE; first frame bits unchanged.
- Reset pulsed at TX bit 30 -> nss=1, sclk=0 within the reset; no rsp_valid; next request completes normally.
- CLK_DIV=1, GAP_CYCLES=1, opa=0xFFFFFFFF, opb=0 -> 134-cycle TX, exactly 67 sclk rises, 32 rises in RX, correct result.
